// File: rtl/core_launcher.sv
`timescale 1ns/1ps
// Purpose: host-side run controller: load input bytes into data memory, settle, run core with watchdog, drain results.
// Latency: LOAD_LEN load cycles + 2 settle cycles + run length + RES_LEN drain cycles at full handshake rate.
// Backpressure: in_valid gaps stall LOAD; out_ready low stalls DRAIN with out_valid and mem_addr held.
//
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   in_valid/in_ready/in_data    : host input byte stream (accepted only in LOAD)
//   out_valid/out_ready/out_data : host result byte stream (offered only in DRAIN)
//   mem_we/mem_addr/mem_wdata/mem_rdata : data-memory host port (rdata combinational from addr)
//   core_reset/core_req/core_done       : core control: reset level, one-cycle start pulse, done level
//   busy, timeout, run_cycles           : status: not idle, last run aborted, RUN-cycle count
module core_launcher #(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          timeout,
  output logic [15:0]   run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);
  localparam logic [AW-1:0] LOAD_LAST   = AW'(LOAD_LEN - 1);
  localparam logic [AW-1:0] RES_LAST    = AW'(RES_LEN - 1);
  localparam logic [15:0]   RUN_LAST    = 16'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          settle_cnt, settle_cnt_nxt;
  logic [15:0]   run_cycles_nxt;
  logic          timeout_nxt;
  logic          first_run;

  // run_cycles is cleared on SETTLE entry, so it reads zero only in the first RUN cycle.
  assign first_run = (run_cycles == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= 1'b0;
      run_cycles <= 16'd0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      run_cycles <= run_cycles_nxt;
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    run_cycles_nxt = run_cycles;
    timeout_nxt    = timeout;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = 8'h00;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = 8'h00;
    core_reset     = 1'b1;
    core_req       = 1'b0;
    busy           = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        // The triggering byte stays on the bus and is taken in the first LOAD cycle.
        if (in_valid) begin
          state_nxt   = S_LOAD;
          idx_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        mem_addr = LOAD_BASE_A + idx;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          if (idx == LOAD_LAST) begin
            state_nxt      = S_SETTLE;
            idx_nxt        = '0;
            settle_cnt_nxt = 1'b0;
            run_cycles_nxt = 16'd0;
          end else begin
            idx_nxt = idx + AW'(1);
          end
        end
      end

      S_SETTLE: begin
        if (settle_cnt) begin
          state_nxt      = S_RUN;
          settle_cnt_nxt = 1'b0;
        end else begin
          settle_cnt_nxt = 1'b1;
        end
      end

      S_RUN: begin
        core_reset = 1'b0;
        core_req   = first_run;
        if (run_cycles != 16'hFFFF) begin
          run_cycles_nxt = run_cycles + 16'd1;
        end
        // Done is checked before the watchdog so a coincident done is not flagged as a timeout.
        if (!first_run && core_done) begin
          state_nxt = S_DRAIN;
          idx_nxt   = '0;
        end else if (run_cycles >= RUN_LAST) begin
          state_nxt   = S_DRAIN;
          idx_nxt     = '0;
          timeout_nxt = 1'b1;
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        mem_addr  = RES_BASE_A + idx;
        out_data  = mem_rdata;
        if (out_ready) begin
          if (idx == RES_LAST) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + AW'(1);
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_core_launcher.sv
`timescale 1ns/1ps
// Directed bench for core_launcher with LOAD_LEN=4, RES_LEN=2, TIMEOUT=16, RES_BASE=8.
// A per-cycle vector table covers one clean job; tasks cover stalls, early done, watchdog and mid-load reset.
// Data memory is modelled as a write log plus fixed read contents (addr8=A5, addr9=5A).
module tb_core_launcher;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        core_reset;
  logic        core_req;
  logic        core_done;
  logic        busy;
  logic        timeout;
  logic [15:0] run_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_launcher #(
    .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .RES_BASE(8), .RES_LEN(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .busy(busy), .timeout(timeout), .run_cycles(run_cycles)
  );

  assign mem_rdata = (mem_addr == 8'd8) ? 8'hA5 : (mem_addr == 8'd9) ? 8'h5A : 8'h00;

  logic [15:0] wr_log [64];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      wr_log[wr_cnt[5:0]] <= {mem_addr, mem_wdata};
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct packed {
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        core_reset;
    logic        core_req;
    logic        busy;
    logic        timeout;
    logic [15:0] run_cycles;
  } obs_t;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       done;
    obs_t       exp;
  } vec_t;

  function automatic obs_t sample();
    return {in_ready, mem_we, mem_addr, mem_wdata, out_valid, out_data,
            core_reset, core_req, busy, timeout, run_cycles};
  endfunction

  function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic dn,
                              logic ir, logic we, logic [7:0] a, logic [7:0] wd,
                              logic ov, logic [7:0] od, logic cr, logic rq,
                              logic bz, logic to, logic [15:0] rc);
    vec_t r;
    r.iv   = iv;
    r.id   = id;
    r.ordy = ordy;
    r.done = dn;
    r.exp  = {ir, we, a, wd, ov, od, cr, rq, bz, to, rc};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts a job from IDLE and streams base..base+3; returns sampled in the first SETTLE cycle.
  task automatic do_load(input logic [7:0] base, input bit gaps);
    int n;
    int g;
    int b0;
    b0 = wr_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = base;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    g = 0;
    while (n < 4 && g < 40) begin
      @(negedge clk);
      if (gaps && g[0]) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = base + 8'(n);
      end
      #1;
      if (g == 0) check("load_entry_timeout", 32'(timeout), 32'd0);
      if (in_valid) begin
        check("load_we", 32'(mem_we), 32'd1);
        check("load_addr", 32'(mem_addr), 32'(n));
        check("load_wdata", 32'(mem_wdata), 32'(base + 8'(n)));
      end else begin
        check("load_gap_we", 32'(mem_we), 32'd0);
        check("load_gap_ready", 32'(in_ready), 32'd1);
      end
      if (in_valid && in_ready) n++;
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("load_count", 32'(n), 32'd4);
    check("load_wr_count", 32'(wr_cnt - b0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = b0 + i;
      check("load_wr_log", 32'(wr_log[k[5:0]]), 32'({8'(i), 8'(base + 8'(i))}));
    end
    check("settle_core_reset", 32'(core_reset), 32'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (!out_valid && g < 40) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("reach_drain", 32'(out_valid), 32'd1);
  endtask

  // Entered sampled in a DRAIN cycle; ends sampled in the following IDLE cycle.
  task automatic do_drain(input bit toggle, input logic [7:0] e0, input logic [7:0] e1);
    int got;
    int g;
    got = 0;
    g = 0;
    while (got < 2 && g < 40) begin
      out_ready = toggle ? g[0] : 1'b1;
      #1;
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_addr", 32'(mem_addr), 32'(8 + got));
      if (out_ready) begin
        check("drain_data", 32'(out_data), 32'((got == 0) ? e0 : e1));
        got++;
      end
      g++;
      @(negedge clk);
      #1;
    end
    out_ready = 1'b0;
    check("drain_count", 32'(got), 32'd2);
    check("drain_idle_busy", 32'(busy), 32'd0);
    check("drain_idle_valid", 32'(out_valid), 32'd0);
  endtask

  vec_t tbl [17];
  int   run_n;
  int   b0;
  int   g;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    core_done = 1'b0;

    tbl[0]  = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, H, L, L, L, 16'd0);
    tbl[1]  = mk(H, 8'h11, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, H, L, L, L, 16'd0);
    tbl[2]  = mk(H, 8'h11, L, L,  H, H, 8'h00, 8'h11, L, 8'h00, H, L, H, L, 16'd0);
    tbl[3]  = mk(H, 8'h22, L, L,  H, H, 8'h01, 8'h22, L, 8'h00, H, L, H, L, 16'd0);
    tbl[4]  = mk(H, 8'h33, L, L,  H, H, 8'h02, 8'h33, L, 8'h00, H, L, H, L, 16'd0);
    tbl[5]  = mk(H, 8'h44, L, L,  H, H, 8'h03, 8'h44, L, 8'h00, H, L, H, L, 16'd0);
    tbl[6]  = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, H, L, H, L, 16'd0);
    tbl[7]  = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, H, L, H, L, 16'd0);
    tbl[8]  = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, L, H, H, L, 16'd0);
    tbl[9]  = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, L, L, H, L, 16'd1);
    tbl[10] = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, L, L, H, L, 16'd2);
    tbl[11] = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, L, L, H, L, 16'd3);
    tbl[12] = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, L, L, H, L, 16'd4);
    tbl[13] = mk(L, 8'h00, L, H,  L, L, 8'h00, 8'h00, L, 8'h00, L, L, H, L, 16'd5);
    tbl[14] = mk(L, 8'h00, H, L,  L, L, 8'h08, 8'h00, H, 8'hA5, H, L, H, L, 16'd6);
    tbl[15] = mk(L, 8'h00, H, L,  L, L, 8'h09, 8'h00, H, 8'h5A, H, L, H, L, 16'd6);
    tbl[16] = mk(L, 8'h00, L, L,  L, L, 8'h00, 8'h00, L, 8'h00, H, L, L, L, 16'd6);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check_obs("reset_state", sample(),
              {L, L, 8'h00, 8'h00, L, 8'h00, H, L, L, L, 16'd0});
    @(negedge clk);
    reset = 1'b0;

    // One clean job, cycle by cycle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      core_done = tbl[i].done;
      #1;
      check_obs($sformatf("vec_row%0d", i), sample(), tbl[i].exp);
    end
    out_ready = 1'b0;

    // Done held from SETTLE: ignored in the first RUN cycle
    do_load(8'h20, 1'b0);
    core_done = 1'b1;
    @(negedge clk); #1;
    check("early_settle2_reset", 32'(core_reset), 32'd1);
    check("early_settle2_req", 32'(core_req), 32'd0);
    @(negedge clk); #1;
    check("early_run1_req", 32'(core_req), 32'd1);
    check("early_run1_reset", 32'(core_reset), 32'd0);
    @(negedge clk); #1;
    check("early_run2_reset", 32'(core_reset), 32'd0);
    check("early_run2_req", 32'(core_req), 32'd0);
    check("early_run2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    check("early_drain_valid", 32'(out_valid), 32'd1);
    check("early_run_cycles", 32'(run_cycles), 32'd2);
    check("early_timeout", 32'(timeout), 32'd0);
    core_done = 1'b0;
    do_drain(1'b0, 8'hA5, 8'h5A);

    // Watchdog: done never raised
    do_load(8'h40, 1'b0);
    run_n = 0;
    g = 0;
    while (!out_valid && g < 100) begin
      if (!core_reset) run_n++;
      g++;
      @(negedge clk);
      #1;
    end
    check("wd_run_len", 32'(run_n), 32'd16);
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_run_cycles", 32'(run_cycles), 32'd16);
    do_drain(1'b0, 8'hA5, 8'h5A);
    check("wd_timeout_idle_hold", 32'(timeout), 32'd1);
    check("wd_run_cycles_idle_hold", 32'(run_cycles), 32'd16);

    // Stalled handshakes on both sides; next job clears timeout on LOAD entry
    do_load(8'h60, 1'b1);
    core_done = 1'b1;
    wait_drain();
    core_done = 1'b0;
    do_drain(1'b1, 8'hA5, 8'h5A);

    // Reset in the middle of LOAD
    b0 = wr_cnt;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h70; #1;
    @(negedge clk); #1;
    @(negedge clk); in_data = 8'h71; #1;
    @(negedge clk); reset = 1'b1; in_valid = 1'b0; #1;
    @(negedge clk); reset = 1'b0; #1;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_core_reset", 32'(core_reset), 32'd1);
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    check("mid_reset_run_cycles", 32'(run_cycles), 32'd0);
    check("mid_reset_writes", 32'(wr_cnt - b0), 32'd2);
    do_load(8'h80, 1'b0);
    core_done = 1'b1;
    wait_drain();
    core_done = 1'b0;
    do_drain(1'b0, 8'hA5, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
